exec_unit: RTL and testbench



---
 rtl/exec_unit.sv | 96 +++++++++
 tb/tb_exec_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// exec_unit: single-issue execution unit (negate / iterative square) feeding the CDB.
// Latency: negate 1 cycle; square MUL_BITS cycles (one multiplier bit per cycle, LSB first).
// Backpressure: result held in DONE until grant; requireAC low while busy or holding without grant.
//
// Ports:
//   clk, nRST                  - clock, async active-low reset
//   require/opIn/dataIn/labelIn - instruction queue head (op 0 = negate, 1 = square)
//   requireAC                  - combinational accept to the queue (pops on require && requireAC)
//   bcReq/bcLabel/bcData       - registered CDB request with tag and result
//   grant                      - CDB arbiter grant; consumes the held result on this edge
module exec_unit #(
  parameter int MUL_BITS = 16
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        require,
  input  logic        opIn,
  input  logic [31:0] dataIn,
  input  logic [3:0]  labelIn,
  output logic        requireAC,
  output logic        bcReq,
  output logic [3:0]  bcLabel,
  output logic [31:0] bcData,
  input  logic        grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [31:0]         mcand;   // multiplicand, shifted left each iteration
  logic [MUL_BITS-1:0] mplier;  // multiplier, shifted right each iteration
  logic [4:0]          cnt;
  logic [31:0]         acc;

  logic        accept;
  logic [31:0] add_term;
  logic [31:0] acc_next;

  // A held result that is granted this cycle frees the unit in the same edge,
  // which is what allows one negate per cycle under continuous grant.
  assign requireAC = (state == IDLE) || ((state == DONE) && grant);
  assign accept    = require && requireAC;
  assign bcReq     = (state == DONE);

  assign add_term = mplier[0] ? mcand : 32'd0;
  assign acc_next = acc + add_term;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      acc     <= '0;
      bcLabel <= '0;
      bcData  <= '0;
    end else if (accept) begin
      // Accept path is shared by IDLE and DONE+grant (back-to-back issue).
      bcLabel <= labelIn;
      if (!opIn) begin
        bcData <= ~dataIn + 32'd1;
        state  <= DONE;
      end else begin
        // Upper operand bits are ignored; only the low MUL_BITS are squared.
        mcand  <= 32'(dataIn[MUL_BITS-1:0]);
        mplier <= dataIn[MUL_BITS-1:0];
        cnt    <= 5'(MUL_BITS);
        acc    <= '0;
        state  <= MUL;
      end
    end else begin
      case (state)
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 5'd1;
          // Last bit processed on this edge: publish the finished product.
          if (cnt == 5'd1) begin
            bcData <= acc_next;
            state  <= DONE;
          end
        end
        DONE: begin
          if (grant) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed testbench for exec_unit: reset, negate hold, square latency,
// back-to-back negates, reset during multiply, and grant outside DONE.
module tb_exec_unit;

  logic        clk;
  logic        nRST;
  logic        require;
  logic        opIn;
  logic [31:0] dataIn;
  logic [3:0]  labelIn;
  logic        requireAC;
  logic        bcReq;
  logic [3:0]  bcLabel;
  logic [31:0] bcData;
  logic        grant;

  int total;
  int bad;

  exec_unit #(.MUL_BITS(16)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .require   (require),
    .opIn      (opIn),
    .dataIn    (dataIn),
    .labelIn   (labelIn),
    .requireAC (requireAC),
    .bcReq     (bcReq),
    .bcLabel   (bcLabel),
    .bcData    (bcData),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; require = 1'b0; opIn = 1'b0; dataIn = '0; labelIn = '0; grant = 1'b0;
    step();
    step();
    nRST = 1'b1;
    #1;
    total++; if (requireAC !== 1'b1) begin bad++; $display("FAIL reset_requireAC got=%b exp=1", requireAC); end
    total++; if (bcReq !== 1'b0) begin bad++; $display("FAIL reset_bcReq got=%b exp=0", bcReq); end
    total++; if (bcLabel !== 4'd0) begin bad++; $display("FAIL reset_bcLabel got=%0d exp=0", bcLabel); end
    total++; if (bcData !== 32'd0) begin bad++; $display("FAIL reset_bcData got=%h exp=0", bcData); end
  endtask

  task automatic test_negate_hold();
    step();
    require = 1'b1; opIn = 1'b0; dataIn = 32'h0000_0005; labelIn = 4'd3; grant = 1'b0;
    step();
    require = 1'b0; dataIn = '0; labelIn = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (bcReq !== 1'b1) begin bad++; $display("FAIL neg_bcReq cyc=%0d got=%b exp=1", i, bcReq); end
      total++; if (bcData !== 32'hFFFF_FFFB) begin bad++; $display("FAIL neg_bcData cyc=%0d got=%h exp=fffffffb", i, bcData); end
      total++; if (bcLabel !== 4'd3) begin bad++; $display("FAIL neg_bcLabel cyc=%0d got=%0d exp=3", i, bcLabel); end
      total++; if (requireAC !== 1'b0) begin bad++; $display("FAIL neg_requireAC_hold cyc=%0d got=%b exp=0", i, requireAC); end
      step();
    end
    grant = 1'b1;
    #1;
    total++; if (requireAC !== 1'b1) begin bad++; $display("FAIL neg_requireAC_grant got=%b exp=1", requireAC); end
    step();
    grant = 1'b0;
    #1;
    total++; if (bcReq !== 1'b0) begin bad++; $display("FAIL neg_idle_bcReq got=%b exp=0", bcReq); end
    total++; if (requireAC !== 1'b1) begin bad++; $display("FAIL neg_idle_requireAC got=%b exp=1", requireAC); end
  endtask

  // Issue a square and return the number of edges until bcReq rises.
  // pulse_grant toggles grant during MUL to show it is ignored there.
  task automatic run_square(input logic [31:0] d, input logic [3:0] lbl,
                            input bit pulse_grant, output int cyc);
    require = 1'b1; opIn = 1'b1; dataIn = d; labelIn = lbl; grant = 1'b0;
    step();
    require = 1'b0; dataIn = '0; labelIn = '0;
    cyc = 0;
    while (bcReq !== 1'b1 && cyc < 40) begin
      grant = pulse_grant ? cyc[0] : 1'b0;
      #1;
      total++; if (requireAC !== 1'b0) begin bad++; $display("FAIL sq_requireAC_mul cyc=%0d got=%b exp=0", cyc, requireAC); end
      step();
      cyc++;
    end
    grant = 1'b0;
    #1;
  endtask

  task automatic test_square();
    int cyc;
    run_square(32'hFFFF_1234, 4'd5, 1'b0, cyc);
    total++; if (cyc !== 16) begin bad++; $display("FAIL sq_latency got=%0d exp=16", cyc); end
    total++; if (bcData !== 32'h014B_5A90) begin bad++; $display("FAIL sq_bcData got=%h exp=014b5a90", bcData); end
    total++; if (bcLabel !== 4'd5) begin bad++; $display("FAIL sq_bcLabel got=%0d exp=5", bcLabel); end
    grant = 1'b1;
    step();
    grant = 1'b0;
    #1;
    total++; if (bcReq !== 1'b0) begin bad++; $display("FAIL sq_release_bcReq got=%b exp=0", bcReq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hFFFF_FFFF; exp_d[1] = 32'hFFFF_FFFE; exp_d[2] = 32'hFFFF_FFFD;
    grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      require = 1'b1; opIn = 1'b0; dataIn = 32'(i + 1); labelIn = 4'(i + 1);
      #1;
      total++; if (requireAC !== 1'b1) begin bad++; $display("FAIL b2b_requireAC idx=%0d got=%b exp=1", i, requireAC); end
      step();
      total++; if (bcReq !== 1'b1) begin bad++; $display("FAIL b2b_bcReq idx=%0d got=%b exp=1", i, bcReq); end
      total++; if (bcData !== exp_d[i]) begin bad++; $display("FAIL b2b_bcData idx=%0d got=%h exp=%h", i, bcData, exp_d[i]); end
      total++; if (bcLabel !== 4'(i + 1)) begin bad++; $display("FAIL b2b_bcLabel idx=%0d got=%0d exp=%0d", i, bcLabel, i + 1); end
    end
    require = 1'b0; dataIn = '0; labelIn = '0;
    step();
    grant = 1'b0;
    #1;
    total++; if (bcReq !== 1'b0) begin bad++; $display("FAIL b2b_drain_bcReq got=%b exp=0", bcReq); end
  endtask

  task automatic test_reset_mid_mul();
    require = 1'b1; opIn = 1'b1; dataIn = 32'h0000_00FF; labelIn = 4'd9; grant = 1'b0;
    step();
    require = 1'b0; dataIn = '0; labelIn = '0;
    repeat (7) step();
    #2;
    nRST = 1'b0;
    #1;
    total++; if (bcReq !== 1'b0) begin bad++; $display("FAIL rmm_bcReq got=%b exp=0", bcReq); end
    total++; if (bcLabel !== 4'd0) begin bad++; $display("FAIL rmm_bcLabel got=%0d exp=0", bcLabel); end
    total++; if (bcData !== 32'd0) begin bad++; $display("FAIL rmm_bcData got=%h exp=0", bcData); end
    total++; if (requireAC !== 1'b1) begin bad++; $display("FAIL rmm_requireAC got=%b exp=1", requireAC); end
    step();
    step();
    nRST = 1'b1;
    require = 1'b1; opIn = 1'b0; dataIn = 32'd0; labelIn = 4'd4;
    step();
    require = 1'b0; labelIn = '0;
    total++; if (bcReq !== 1'b1) begin bad++; $display("FAIL rmm_neg_bcReq got=%b exp=1", bcReq); end
    total++; if (bcData !== 32'd0) begin bad++; $display("FAIL rmm_neg_bcData got=%h exp=0", bcData); end
    total++; if (bcLabel !== 4'd4) begin bad++; $display("FAIL rmm_neg_bcLabel got=%0d exp=4", bcLabel); end
    grant = 1'b1;
    step();
    grant = 1'b0;
  endtask

  task automatic test_grant_outside_done();
    int cyc;
    require = 1'b0; grant = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bcReq !== 1'b0) begin bad++; $display("FAIL god_idle_bcReq cyc=%0d got=%b exp=0", i, bcReq); end
      total++; if (requireAC !== 1'b1) begin bad++; $display("FAIL god_idle_requireAC cyc=%0d got=%b exp=1", i, requireAC); end
    end
    grant = 1'b0;
    run_square(32'h0000_0003, 4'd6, 1'b1, cyc);
    total++; if (cyc !== 16) begin bad++; $display("FAIL god_sq_latency got=%0d exp=16", cyc); end
    total++; if (bcData !== 32'd9) begin bad++; $display("FAIL god_sq_bcData got=%h exp=9", bcData); end
    total++; if (bcLabel !== 4'd6) begin bad++; $display("FAIL god_sq_bcLabel got=%0d exp=6", bcLabel); end
    grant = 1'b1;
    step();
    grant = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_negate_hold();
    test_square();
    test_back_to_back();
    test_reset_mid_mul();
    test_grant_outside_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
